// File: rtl/vector_uop_sequencer.sv
// vector_uop_sequencer
//   Decode-side driver of the element counter. Takes one decoded vector
//   instruction at a time, programs the counter (vstart/vl/sew, clear,
//   de_en, stall, ex_return) and turns the counter's offset/uop_vl/done
//   stream into a valid/ready micro-op stream toward execute. A flushed
//   instruction stays saved and can be resumed from a new vstart on
//   trap return.
// Ports
//   CLK, nRST                  clock (rising edge), async active-low reset
//   instr_valid/ready          decoded instruction handshake
//   instr_word/vl/vstart/sew   instruction payload and CSR snapshot
//   ec_vstart/vl/sew           counter programming (from latched registers)
//   ec_clear/de_en/stall       counter control
//   ec_ex_return               counter trap-return pulse
//   ec_offset/uop_vl/
//   ec_shift_ena/done          counter status for the current uop
//   uop_valid/ready            micro-op handshake toward execute
//   uop_instr/offset/vl/
//   uop_shift/last             micro-op payload
//   ex_flush                   kill the in-flight instruction
//   ex_return/ex_vstart        resume the saved instruction from ex_vstart
//   busy                       sequencer is not idle
module vector_uop_sequencer #(
  parameter int OFFSET_W = 5,
  parameter int UVL_W    = 5
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr_word,
  input  logic [31:0]         instr_vl,
  input  logic [31:0]         instr_vstart,
  input  logic [1:0]          instr_sew,
  output logic [31:0]         ec_vstart,
  output logic [31:0]         ec_vl,
  output logic [1:0]          ec_sew,
  output logic                ec_clear,
  output logic                ec_de_en,
  output logic                ec_stall,
  output logic                ec_ex_return,
  input  logic [OFFSET_W-1:0] ec_offset,
  input  logic [UVL_W-1:0]    ec_uop_vl,
  input  logic                ec_shift_ena,
  input  logic                ec_done,
  output logic                uop_valid,
  input  logic                uop_ready,
  output logic [31:0]         uop_instr,
  output logic [OFFSET_W-1:0] uop_offset,
  output logic [UVL_W-1:0]    uop_vl,
  output logic                uop_shift,
  output logic                uop_last,
  input  logic                ex_flush,
  input  logic                ex_return,
  input  logic [31:0]         ex_vstart,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]  state;
  logic [31:0] instr_q, vl_q, vstart_q;
  logic [1:0]  sew_q;
  logic        have_saved;
  logic        ret_q;

  logic idle, resume, accept, empty_instr, handshake;

  assign idle   = (state == IDLE);
  // A resume outranks a new instruction; a flush outranks both.
  assign resume      = idle & ex_return & have_saved & ~ex_flush;
  assign instr_ready = idle & ~ex_flush & ~(ex_return & have_saved);
  assign accept      = instr_valid & instr_ready;
  assign empty_instr = (instr_vl == 32'd0) | (instr_vstart >= instr_vl);

  assign uop_valid = (state == ISSUE) & ~ex_flush;
  assign handshake = uop_valid & uop_ready;

  assign ec_vstart    = vstart_q;
  assign ec_vl        = vl_q;
  assign ec_sew       = sew_q;
  assign ec_clear     = (state == INIT) | ex_flush;
  assign ec_de_en     = (state == ISSUE);
  // Holding the counter while execute back-pressures keeps uop_* stable.
  assign ec_stall     = uop_valid & ~uop_ready;
  // Registered so the pulse lines up with the freshly loaded ec_vstart.
  assign ec_ex_return = ret_q;

  assign uop_instr  = instr_q;
  assign uop_offset = ec_offset;
  assign uop_vl     = ec_uop_vl;
  assign uop_shift  = ec_shift_ena;
  assign uop_last   = ec_done;

  assign busy = ~idle;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      instr_q    <= '0;
      vl_q       <= '0;
      vstart_q   <= '0;
      sew_q      <= '0;
      have_saved <= 1'b0;
      ret_q      <= 1'b0;
    end else begin
      ret_q <= resume & (ex_vstart < vl_q);
      if (ex_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (resume) begin
              vstart_q <= ex_vstart;
              if (ex_vstart >= vl_q) have_saved <= 1'b0;
              else                   state      <= INIT;
            end else if (accept) begin
              instr_q    <= instr_word;
              vl_q       <= instr_vl;
              vstart_q   <= instr_vstart;
              sew_q      <= instr_sew;
              have_saved <= 1'b1;
              if (!empty_instr) state <= INIT;
            end
          end
          INIT: state <= ISSUE;
          ISSUE: begin
            if (handshake & ec_done) begin
              state      <= IDLE;
              have_saved <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Directed bench for vector_uop_sequencer with a simple element-counter
// model: 4 elements per uop, done when offset+4 >= vl.
module tb_vector_uop_sequencer;
  localparam int OFFSET_W = 5;
  localparam int UVL_W    = 5;

  logic                CLK = 1'b0;
  logic                nRST;
  logic                instr_valid, instr_ready;
  logic [31:0]         instr_word, instr_vl, instr_vstart;
  logic [1:0]          instr_sew;
  logic [31:0]         ec_vstart, ec_vl;
  logic [1:0]          ec_sew;
  logic                ec_clear, ec_de_en, ec_stall, ec_ex_return;
  logic [OFFSET_W-1:0] ec_offset;
  logic [UVL_W-1:0]    ec_uop_vl;
  logic                ec_shift_ena, ec_done;
  logic                uop_valid, uop_ready;
  logic [31:0]         uop_instr;
  logic [OFFSET_W-1:0] uop_offset;
  logic [UVL_W-1:0]    uop_vl;
  logic                uop_shift, uop_last;
  logic                ex_flush, ex_return;
  logic [31:0]         ex_vstart;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;

  vector_uop_sequencer #(.OFFSET_W(OFFSET_W), .UVL_W(UVL_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .instr_vl(instr_vl), .instr_vstart(instr_vstart), .instr_sew(instr_sew),
    .ec_vstart(ec_vstart), .ec_vl(ec_vl), .ec_sew(ec_sew), .ec_clear(ec_clear),
    .ec_de_en(ec_de_en), .ec_stall(ec_stall), .ec_ex_return(ec_ex_return),
    .ec_offset(ec_offset), .ec_uop_vl(ec_uop_vl), .ec_shift_ena(ec_shift_ena), .ec_done(ec_done),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_instr(uop_instr), .uop_offset(uop_offset),
    .uop_vl(uop_vl), .uop_shift(uop_shift), .uop_last(uop_last),
    .ex_flush(ex_flush), .ex_return(ex_return), .ex_vstart(ex_vstart), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // element counter model
  logic [OFFSET_W-1:0] cnt_off;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       cnt_off <= '0;
    else if (ec_clear | ec_ex_return) cnt_off <= ec_vstart[OFFSET_W-1:0];
    else if (ec_de_en & ~ec_stall)   cnt_off <= cnt_off + OFFSET_W'(4);
  end
  always_comb begin
    ec_offset    = cnt_off;
    ec_done      = (32'(cnt_off) + 32'd4) >= ec_vl;
    ec_uop_vl    = ec_done ? UVL_W'(ec_vl - 32'(cnt_off)) : UVL_W'(4);
    ec_shift_ena = ec_de_en & ~ec_stall;
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic mid();  @(negedge CLK);     endtask

  task automatic set_instr(input logic [31:0] w, input logic [31:0] vl, input logic [31:0] vs);
    instr_word = w; instr_vl = vl; instr_vstart = vs; instr_sew = 2'd2; instr_valid = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; instr_valid = 0; instr_word = 0; instr_vl = 0; instr_vstart = 0; instr_sew = 0;
    uop_ready = 0; ex_flush = 0; ex_return = 0; ex_vstart = 0;
    #2;
    n_tests++; if (uop_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_uop_valid got=%0h exp=0", uop_valid); end
    n_tests++; if (ec_clear !== 1'b0)     begin n_fail++; $display("FAIL rst_ec_clear got=%0h exp=0", ec_clear); end
    n_tests++; if (instr_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_instr_ready got=%0h exp=1", instr_ready); end
    n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_tests++; if (ec_ex_return !== 1'b0) begin n_fail++; $display("FAIL rst_ec_ex_return got=%0h exp=0", ec_ex_return); end
    n_tests++; if (ec_de_en !== 1'b0)     begin n_fail++; $display("FAIL rst_ec_de_en got=%0h exp=0", ec_de_en); end
    #10 nRST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    uop_ready = 1'b1; set_instr(32'hA5A5_0001, 32'd8, 32'd0);
    mid();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%0h exp=1", instr_ready); end
    tick(); instr_valid = 1'b0;
    mid();
    n_tests++; if (ec_clear !== 1'b1)    begin n_fail++; $display("FAIL basic_clear got=%0h exp=1", ec_clear); end
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL basic_init_ready got=%0h exp=0", instr_ready); end
    n_tests++; if (uop_valid !== 1'b0)   begin n_fail++; $display("FAIL basic_init_valid got=%0h exp=0", uop_valid); end
    n_tests++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL basic_busy got=%0h exp=1", busy); end
    tick(); mid();
    n_tests++; if (uop_valid !== 1'b1)   begin n_fail++; $display("FAIL basic_u0_valid got=%0h exp=1", uop_valid); end
    n_tests++; if (uop_offset !== 5'd0)  begin n_fail++; $display("FAIL basic_u0_off got=%0d exp=0", uop_offset); end
    n_tests++; if (uop_last !== 1'b0)    begin n_fail++; $display("FAIL basic_u0_last got=%0h exp=0", uop_last); end
    n_tests++; if (uop_vl !== 5'd4)      begin n_fail++; $display("FAIL basic_u0_vl got=%0d exp=4", uop_vl); end
    n_tests++; if (uop_instr !== 32'hA5A5_0001) begin n_fail++; $display("FAIL basic_instr got=%0h exp=a5a50001", uop_instr); end
    n_tests++; if (ec_vl !== 32'd8 || ec_sew !== 2'd2) begin n_fail++; $display("FAIL basic_ec_cfg got=%0d/%0d exp=8/2", ec_vl, ec_sew); end
    n_tests++; if (ec_de_en !== 1'b1 || ec_stall !== 1'b0) begin n_fail++; $display("FAIL basic_ctl got=%0h/%0h exp=1/0", ec_de_en, ec_stall); end
    tick(); mid();
    n_tests++; if (uop_valid !== 1'b1 || uop_offset !== 5'd4) begin n_fail++; $display("FAIL basic_u1 got=%0h/%0d exp=1/4", uop_valid, uop_offset); end
    n_tests++; if (uop_last !== 1'b1)    begin n_fail++; $display("FAIL basic_u1_last got=%0h exp=1", uop_last); end
    tick(); mid();
    n_tests++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got=%0h/%0h exp=1/0", instr_ready, busy); end
    n_tests++; if (uop_valid !== 1'b0 || ec_de_en !== 1'b0) begin n_fail++; $display("FAIL basic_idle_out got=%0h/%0h exp=0/0", uop_valid, ec_de_en); end
    tick();
  endtask

  task automatic test_stall();
    int st, nu, bad; logic fin; logic [OFFSET_W-1:0] o0, o1;
    st = 0; nu = 0; bad = 0; o0 = '1; o1 = '1;
    uop_ready = 1'b0; set_instr(32'h0000_0E0E, 32'd8, 32'd0);
    tick(); instr_valid = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      mid();
      if (ec_stall) begin st++; if (uop_offset !== 5'd0) bad++; end
      if (uop_valid & uop_ready) begin if (nu == 0) o0 = uop_offset; else o1 = uop_offset; nu++; end
      fin = uop_valid & uop_ready & uop_last;
      tick(); uop_ready = (c >= 2);
      if (fin) break;
    end
    n_tests++; if (st != 3)   begin n_fail++; $display("FAIL stall_cycles got=%0d exp=3", st); end
    n_tests++; if (bad != 0)  begin n_fail++; $display("FAIL stall_hold got=%0d exp=0", bad); end
    n_tests++; if (nu != 2)   begin n_fail++; $display("FAIL stall_uops got=%0d exp=2", nu); end
    n_tests++; if (o0 !== 5'd0 || o1 !== 5'd4) begin n_fail++; $display("FAIL stall_offs got=%0d,%0d exp=0,4", o0, o1); end
    mid();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle got=%0h exp=0", busy); end
    tick();
  endtask

  task automatic test_zero_uops();
    int seen;
    seen = 0;
    uop_ready = 1'b1; set_instr(32'h0000_000F, 32'd0, 32'd0);
    mid();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL zero_vl_ready got=%0h exp=1", instr_ready); end
    tick(); set_instr(32'h0000_0009, 32'd8, 32'd9);
    mid();
    n_tests++; if (busy !== 1'b0 || ec_clear !== 1'b0) begin n_fail++; $display("FAIL zero_vl_idle got=%0h/%0h exp=0/0", busy, ec_clear); end
    n_tests++; if (instr_ready !== 1'b1 || ec_vl !== 32'd0) begin n_fail++; $display("FAIL zero_vl_latch got=%0h/%0d exp=1/0", instr_ready, ec_vl); end
    tick(); instr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mid();
      if (busy || uop_valid || ec_clear) seen++;
      tick();
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL zero_vs_busy got=%0d exp=0", seen); end
    n_tests++; if (ec_vstart !== 32'd9 || ec_vl !== 32'd8) begin n_fail++; $display("FAIL zero_vs_latch got=%0d/%0d exp=9/8", ec_vstart, ec_vl); end
  endtask

  task automatic test_flush_return();
    uop_ready = 1'b1; set_instr(32'h0000_0B0B, 32'd16, 32'd0);
    tick(); instr_valid = 1'b0;
    tick(); mid();
    n_tests++; if (uop_valid !== 1'b1 || uop_offset !== 5'd0) begin n_fail++; $display("FAIL flush_u0 got=%0h/%0d exp=1/0", uop_valid, uop_offset); end
    tick(); ex_flush = 1'b1; mid();
    n_tests++; if (uop_valid !== 1'b0 || ec_clear !== 1'b1) begin n_fail++; $display("FAIL flush_cycle got=%0h/%0h exp=0/1", uop_valid, ec_clear); end
    tick(); ex_flush = 1'b0; mid();
    n_tests++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle got=%0h/%0h exp=0/1", busy, instr_ready); end
    tick(); ex_return = 1'b1; ex_vstart = 32'd8; mid();
    n_tests++; if (instr_ready !== 1'b0 || ec_ex_return !== 1'b0) begin n_fail++; $display("FAIL ret_req got=%0h/%0h exp=0/0", instr_ready, ec_ex_return); end
    tick(); ex_return = 1'b0; mid();
    n_tests++; if (ec_ex_return !== 1'b1 || ec_vstart !== 32'd8) begin n_fail++; $display("FAIL ret_pulse got=%0h/%0d exp=1/8", ec_ex_return, ec_vstart); end
    tick(); mid();
    n_tests++; if (uop_valid !== 1'b1 || uop_offset !== 5'd8 || uop_last !== 1'b0) begin n_fail++; $display("FAIL ret_u0 got=%0h/%0d/%0h exp=1/8/0", uop_valid, uop_offset, uop_last); end
    n_tests++; if (uop_instr !== 32'h0000_0B0B || ec_ex_return !== 1'b0) begin n_fail++; $display("FAIL ret_instr got=%0h/%0h exp=b0b/0", uop_instr, ec_ex_return); end
    tick(); mid();
    n_tests++; if (uop_valid !== 1'b1 || uop_offset !== 5'd12 || uop_last !== 1'b1) begin n_fail++; $display("FAIL ret_u1 got=%0h/%0d/%0h exp=1/12/1", uop_valid, uop_offset, uop_last); end
    tick(); mid();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ret_done got=%0h exp=0", busy); end
    tick();
  endtask

  task automatic test_return_vs_instr();
    uop_ready = 1'b1; set_instr(32'h0000_0C0C, 32'd8, 32'd0);
    tick(); instr_valid = 1'b0;
    tick(); ex_flush = 1'b1; mid();
    n_tests++; if (uop_valid !== 1'b0) begin n_fail++; $display("FAIL rvi_flush got=%0h exp=0", uop_valid); end
    tick(); ex_flush = 1'b0; ex_return = 1'b1; ex_vstart = 32'd4; set_instr(32'h0000_0D0D, 32'd12, 32'd0);
    mid();
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rvi_ready got=%0h exp=0", instr_ready); end
    tick(); ex_return = 1'b0; mid();
    n_tests++; if (ec_ex_return !== 1'b1 || ec_vl !== 32'd8 || ec_vstart !== 32'd4) begin n_fail++; $display("FAIL rvi_resume got=%0h/%0d/%0d exp=1/8/4", ec_ex_return, ec_vl, ec_vstart); end
    tick(); mid();
    n_tests++; if (uop_instr !== 32'h0000_0C0C || uop_offset !== 5'd4 || uop_last !== 1'b1) begin n_fail++; $display("FAIL rvi_old_uop got=%0h/%0d/%0h exp=c0c/4/1", uop_instr, uop_offset, uop_last); end
    tick(); mid();
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rvi_new_ready got=%0h exp=1", instr_ready); end
    tick(); instr_valid = 1'b0; mid();
    n_tests++; if (ec_clear !== 1'b1 || ec_vl !== 32'd12) begin n_fail++; $display("FAIL rvi_new_init got=%0h/%0d exp=1/12", ec_clear, ec_vl); end
    tick(); mid();
    n_tests++; if (uop_instr !== 32'h0000_0D0D || uop_offset !== 5'd0) begin n_fail++; $display("FAIL rvi_new_uop got=%0h/%0d exp=d0d/0", uop_instr, uop_offset); end
    tick(); tick(); tick(); mid();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rvi_done got=%0h exp=0", busy); end
    tick();
  endtask

  task automatic test_async_reset();
    uop_ready = 1'b1; set_instr(32'h0000_0A0A, 32'd16, 32'd0);
    tick(); instr_valid = 1'b0;
    tick(); mid();
    #1 nRST = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || uop_valid !== 1'b0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL arst_idle got=%0h/%0h/%0h exp=0/0/1", busy, uop_valid, instr_ready); end
    #1 nRST = 1'b1; ex_return = 1'b1; ex_vstart = 32'd4;
    #1;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL arst_lost_ready got=%0h exp=1", instr_ready); end
    tick(); ex_return = 1'b0; mid();
    n_tests++; if (busy !== 1'b0 || ec_ex_return !== 1'b0) begin n_fail++; $display("FAIL arst_no_resume got=%0h/%0h exp=0/0", busy, ec_ex_return); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_uops();
    test_flush_return();
    test_return_vs_instr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
